// File: rtl/id_operand.sv
// id_operand: RV32I decode-stage operand fetch with EX/MEM forwarding and load-use hazard detection.
module id_operand (
    input  logic        clk,
    input  logic        reset_,
    input  logic [31:0] if_insn,
    input  logic        if_en,
    input  logic        stall,
    input  logic        flush,
    output logic [4:0]  gpr_rd_addr_0,
    output logic [4:0]  gpr_rd_addr_1,
    input  logic [31:0] gpr_rd_data_0,
    input  logic [31:0] gpr_rd_data_1,
    input  logic        ex_en,
    input  logic        ex_we_,
    input  logic        ex_ld,
    input  logic [4:0]  ex_dst_addr,
    input  logic [31:0] ex_fwd_data,
    input  logic        mem_en,
    input  logic        mem_we_,
    input  logic [4:0]  mem_dst_addr,
    input  logic [31:0] mem_fwd_data,
    output logic        id_en,
    output logic        id_we_,
    output logic        id_ld,
    output logic [4:0]  id_dst_addr,
    output logic [31:0] id_insn,
    output logic [31:0] id_rs1_data,
    output logic [31:0] id_rs2_data,
    output logic        ld_hazard
);
    logic        en_q, en_d, we_q, we_d, ld_q, ld_d;
    logic [4:0]  dst_q, dst_d;
    logic [31:0] insn_q, insn_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [31:0] op1, op2;
    logic [6:0]  opcode;
    logic        ex_wr, mem_wr, we_dec, ld_dec, capture, bubble;

    assign gpr_rd_addr_0 = if_insn[19:15];
    assign gpr_rd_addr_1 = if_insn[24:20];
    assign opcode        = if_insn[6:0];
    assign ex_wr         = ex_en && !ex_we_;
    assign mem_wr        = mem_en && !mem_we_;
    assign we_dec        = (opcode == 7'b0100011) || (opcode == 7'b1100011);
    assign ld_dec        = (opcode == 7'b0000011);

    // Address 0 short-circuits first, so a zero destination can never forward.
    assign op1 = (gpr_rd_addr_0 == 5'd0) ? 32'h0 :
                 (ex_wr && ex_dst_addr == gpr_rd_addr_0) ? ex_fwd_data :
                 (mem_wr && mem_dst_addr == gpr_rd_addr_0) ? mem_fwd_data : gpr_rd_data_0;
    assign op2 = (gpr_rd_addr_1 == 5'd0) ? 32'h0 :
                 (ex_wr && ex_dst_addr == gpr_rd_addr_1) ? ex_fwd_data :
                 (mem_wr && mem_dst_addr == gpr_rd_addr_1) ? mem_fwd_data : gpr_rd_data_1;

    assign ld_hazard = if_en && ex_wr && ex_ld && (ex_dst_addr != 5'd0) &&
                       (ex_dst_addr == gpr_rd_addr_0 || ex_dst_addr == gpr_rd_addr_1);

    assign capture = !flush && !stall && !ld_hazard;
    assign bubble  = flush || (!stall && ld_hazard);

    always_comb begin
        en_d   = capture ? if_en : bubble ? 1'b0 : en_q;
        we_d   = capture ? (!if_en || we_dec) : bubble ? 1'b1 : we_q;
        ld_d   = capture ? (if_en && ld_dec) : bubble ? 1'b0 : ld_q;
        dst_d  = capture ? if_insn[11:7] : dst_q;
        insn_d = capture ? if_insn : insn_q;
        rs1_d  = capture ? op1 : rs1_q;
        rs2_d  = capture ? op2 : rs2_q;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            en_q   <= 1'b0;
            we_q   <= 1'b1;
            ld_q   <= 1'b0;
            dst_q  <= 5'd0;
            insn_q <= 32'h0;
            rs1_q  <= 32'h0;
            rs2_q  <= 32'h0;
        end else begin
            en_q   <= en_d;
            we_q   <= we_d;
            ld_q   <= ld_d;
            dst_q  <= dst_d;
            insn_q <= insn_d;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
        end
    end

    assign id_en       = en_q;
    assign id_we_      = we_q;
    assign id_ld       = ld_q;
    assign id_dst_addr = dst_q;
    assign id_insn     = insn_q;
    assign id_rs1_data = rs1_q;
    assign id_rs2_data = rs2_q;
endmodule

// File: tb/tb_id_operand.sv
// tb_id_operand: directed scenarios plus randomized cycles against a behavioural pipeline-stage model.
module tb_id_operand;
    logic        clk = 1'b0;
    logic        reset_;
    logic [31:0] if_insn;
    logic        if_en, stall, flush;
    logic [4:0]  gpr_rd_addr_0, gpr_rd_addr_1;
    logic [31:0] gpr_rd_data_0, gpr_rd_data_1;
    logic        ex_en, ex_we_, ex_ld, mem_en, mem_we_;
    logic [4:0]  ex_dst_addr, mem_dst_addr;
    logic [31:0] ex_fwd_data, mem_fwd_data;
    logic        id_en, id_we_, id_ld, ld_hazard;
    logic [4:0]  id_dst_addr;
    logic [31:0] id_insn, id_rs1_data, id_rs2_data;

    logic [31:0] regs [32];
    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ADD_7_5_6 = {7'd0, 5'd6, 5'd5, 3'd0, 5'd7, 7'b0110011};
    localparam logic [31:0] ADD_7_0_6 = {7'd0, 5'd6, 5'd0, 3'd0, 5'd7, 7'b0110011};
    localparam logic [31:0] SW_6_5    = {7'd0, 5'd6, 5'd5, 3'd2, 5'd4, 7'b0100011};

    always #5 clk = ~clk;

    assign gpr_rd_data_0 = regs[gpr_rd_addr_0];
    assign gpr_rd_data_1 = regs[gpr_rd_addr_1];

    id_operand dut (
        .clk(clk), .reset_(reset_), .if_insn(if_insn), .if_en(if_en), .stall(stall), .flush(flush),
        .gpr_rd_addr_0(gpr_rd_addr_0), .gpr_rd_addr_1(gpr_rd_addr_1),
        .gpr_rd_data_0(gpr_rd_data_0), .gpr_rd_data_1(gpr_rd_data_1),
        .ex_en(ex_en), .ex_we_(ex_we_), .ex_ld(ex_ld), .ex_dst_addr(ex_dst_addr), .ex_fwd_data(ex_fwd_data),
        .mem_en(mem_en), .mem_we_(mem_we_), .mem_dst_addr(mem_dst_addr), .mem_fwd_data(mem_fwd_data),
        .id_en(id_en), .id_we_(id_we_), .id_ld(id_ld), .id_dst_addr(id_dst_addr), .id_insn(id_insn),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .ld_hazard(ld_hazard)
    );

    // Architectural value a source register should read given the in-flight writers.
    function automatic logic [31:0] ref_operand(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (ex_en && !ex_we_ && ex_dst_addr == a) return ex_fwd_data;
        if (mem_en && !mem_we_ && mem_dst_addr == a) return mem_fwd_data;
        return regs[a];
    endfunction

    task automatic quiet();
        if_en = 0; stall = 0; flush = 0; if_insn = 32'h0;
        ex_en = 0; ex_we_ = 1; ex_ld = 0; ex_dst_addr = 0; ex_fwd_data = 0;
        mem_en = 0; mem_we_ = 1; mem_dst_addr = 0; mem_fwd_data = 0;
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        quiet();
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[5] = 32'h1234; regs[6] = 32'h00FF;
        reset_ = 0; if_en = 1; if_insn = ADD_7_5_6;
        #26;
        checks++;
        if (id_en !== 0 || id_we_ !== 1 || id_ld !== 0 || id_dst_addr !== 0) begin
            errors++; $display("FAIL reset_ctrl en=%b we_=%b ld=%b dst=%0d want 0 1 0 0", id_en, id_we_, id_ld, id_dst_addr);
        end
        checks++;
        if (id_insn !== 0 || id_rs1_data !== 0 || id_rs2_data !== 0) begin
            errors++; $display("FAIL reset_data insn=%h rs1=%h rs2=%h want 0", id_insn, id_rs1_data, id_rs2_data);
        end
        #1 reset_ = 1;
        edge_sample();
        checks++;
        if (id_en !== 1 || id_insn !== ADD_7_5_6) begin
            errors++; $display("FAIL reset_first_edge en=%b insn=%h want 1 %h", id_en, id_insn, ADD_7_5_6);
        end
    endtask

    task automatic test_plain_read();
        quiet(); if_en = 1; if_insn = ADD_7_5_6;
        #1;
        checks++;
        if (gpr_rd_addr_0 !== 5 || gpr_rd_addr_1 !== 6) begin
            errors++; $display("FAIL rd_addr got %0d %0d want 5 6", gpr_rd_addr_0, gpr_rd_addr_1);
        end
        edge_sample();
        checks++;
        if (id_rs1_data !== 32'h1234 || id_rs2_data !== 32'h00FF || id_dst_addr !== 7 || id_we_ !== 0 || id_en !== 1 || id_ld !== 0) begin
            errors++; $display("FAIL plain_read rs1=%h rs2=%h dst=%0d we_=%b en=%b ld=%b want 1234 00ff 7 0 1 0",
                               id_rs1_data, id_rs2_data, id_dst_addr, id_we_, id_en, id_ld);
        end
    endtask

    task automatic test_forward_priority();
        quiet(); if_en = 1; if_insn = ADD_7_5_6;
        ex_en = 1; ex_we_ = 0; ex_dst_addr = 5; ex_fwd_data = 32'hAAAA;
        mem_en = 1; mem_we_ = 0; mem_dst_addr = 5; mem_fwd_data = 32'hBBBB;
        edge_sample();
        checks++;
        if (id_rs1_data !== 32'hAAAA || id_rs2_data !== 32'h00FF) begin
            errors++; $display("FAIL fwd_ex rs1=%h rs2=%h want aaaa 00ff", id_rs1_data, id_rs2_data);
        end
        ex_en = 0;
        edge_sample();
        checks++;
        if (id_rs1_data !== 32'hBBBB) begin
            errors++; $display("FAIL fwd_mem rs1=%h want bbbb", id_rs1_data);
        end
        mem_we_ = 1;
        edge_sample();
        checks++;
        if (id_rs1_data !== 32'h1234) begin
            errors++; $display("FAIL fwd_mem_we_off rs1=%h want 1234", id_rs1_data);
        end
    endtask

    task automatic test_x0();
        quiet(); if_en = 1; if_insn = ADD_7_0_6;
        regs[0] = 32'hFFFF_0000;
        ex_en = 1; ex_we_ = 0; ex_dst_addr = 0; ex_fwd_data = 32'hDEAD; ex_ld = 1;
        #1;
        checks++;
        if (ld_hazard !== 0) begin
            errors++; $display("FAIL x0_no_hazard ld_hazard=%b want 0", ld_hazard);
        end
        edge_sample();
        checks++;
        if (id_rs1_data !== 32'h0 || id_en !== 1) begin
            errors++; $display("FAIL x0_operand rs1=%h en=%b want 0 1", id_rs1_data, id_en);
        end
    endtask

    task automatic test_load_use();
        quiet(); if_en = 1; if_insn = ADD_7_5_6;
        ex_en = 1; ex_we_ = 0; ex_ld = 1; ex_dst_addr = 5; ex_fwd_data = 32'h9999;
        #1;
        checks++;
        if (ld_hazard !== 1) begin
            errors++; $display("FAIL load_use_hazard ld_hazard=%b want 1", ld_hazard);
        end
        edge_sample();
        checks++;
        if (id_en !== 0 || id_we_ !== 1 || id_ld !== 0) begin
            errors++; $display("FAIL load_use_bubble en=%b we_=%b ld=%b want 0 1 0", id_en, id_we_, id_ld);
        end
        ex_en = 0; ex_ld = 0;
        mem_en = 1; mem_we_ = 0; mem_dst_addr = 5; mem_fwd_data = 32'h55;
        #1;
        checks++;
        if (ld_hazard !== 0) begin
            errors++; $display("FAIL load_use_clear ld_hazard=%b want 0", ld_hazard);
        end
        edge_sample();
        checks++;
        if (id_rs1_data !== 32'h55 || id_en !== 1) begin
            errors++; $display("FAIL load_use_recapture rs1=%h en=%b want 55 1", id_rs1_data, id_en);
        end
    endtask

    task automatic test_flush_stall();
        logic [31:0] h_insn, h_rs1, h_rs2;
        logic [4:0]  h_dst;
        quiet(); if_en = 1; if_insn = ADD_7_5_6;
        edge_sample();
        flush = 1; stall = 1;
        edge_sample();
        checks++;
        if (id_en !== 0 || id_we_ !== 1 || id_ld !== 0) begin
            errors++; $display("FAIL flush_over_stall en=%b we_=%b ld=%b want 0 1 0", id_en, id_we_, id_ld);
        end
        flush = 0; stall = 0; if_insn = SW_6_5;
        edge_sample();
        checks++;
        if (id_en !== 1 || id_we_ !== 1 || id_dst_addr !== 4) begin
            errors++; $display("FAIL store_decode en=%b we_=%b dst=%0d want 1 1 4", id_en, id_we_, id_dst_addr);
        end
        h_insn = SW_6_5; h_dst = 4; h_rs1 = 32'h1234; h_rs2 = 32'h00FF;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            if_insn = $urandom; if_en = 1;
            regs[5] = $urandom;
            edge_sample();
            checks++;
            if (id_en !== 1 || id_we_ !== 1 || id_insn !== h_insn || id_dst_addr !== h_dst || id_rs1_data !== h_rs1 || id_rs2_data !== h_rs2) begin
                errors++; $display("FAIL stall_hold cycle %0d en=%b insn=%h rs1=%h rs2=%h want 1 %h %h %h",
                                   i, id_en, id_insn, id_rs1_data, id_rs2_data, h_insn, h_rs1, h_rs2);
            end
        end
        regs[5] = 32'h1234;
    endtask

    task automatic test_reset_mid_hazard();
        quiet(); if_en = 1; if_insn = ADD_7_5_6; stall = 1;
        ex_en = 1; ex_we_ = 0; ex_ld = 1; ex_dst_addr = 6;
        edge_sample();
        #2 reset_ = 0;
        #1;
        checks++;
        if (id_en !== 0 || id_insn !== 0) begin
            errors++; $display("FAIL async_reset en=%b insn=%h want 0 0", id_en, id_insn);
        end
        checks++;
        if (ld_hazard !== 1) begin
            errors++; $display("FAIL hazard_in_reset ld_hazard=%b want 1", ld_hazard);
        end
        stall = 0; ex_en = 0; ex_ld = 0;
        #1 reset_ = 1;
        edge_sample();
        checks++;
        if (id_en !== 1 || id_insn !== ADD_7_5_6 || id_rs2_data !== 32'h00FF) begin
            errors++; $display("FAIL post_reset_normal en=%b insn=%h rs2=%h want 1 %h 00ff", id_en, id_insn, id_rs2_data, ADD_7_5_6);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [5];
        logic       e_en, e_we, e_ld, hz;
        logic [4:0] e_dst, r1, r2;
        logic [31:0] e_insn, e_rs1, e_rs2;
        ops[0] = 7'b0110011; ops[1] = 7'b0000011; ops[2] = 7'b0100011; ops[3] = 7'b1100011; ops[4] = 7'b0010011;
        quiet();
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        reset_ = 0;
        #2 reset_ = 1;
        e_en = 0; e_we = 1; e_ld = 0; e_dst = 0; e_insn = 0; e_rs1 = 0; e_rs2 = 0;
        for (int c = 0; c < 400; c++) begin
            r1 = 5'($urandom_range(0, 3)); r2 = 5'($urandom_range(0, 3));
            if_insn = {7'($urandom), r2, r1, 3'($urandom), 5'($urandom_range(0, 7)), ops[$urandom_range(0, 4)]};
            if_en = ($urandom_range(0, 4) != 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 5) == 0);
            ex_en = $urandom; ex_we_ = $urandom; ex_ld = $urandom;
            ex_dst_addr = 5'($urandom_range(0, 3)); ex_fwd_data = $urandom;
            mem_en = $urandom; mem_we_ = $urandom;
            mem_dst_addr = 5'($urandom_range(0, 3)); mem_fwd_data = $urandom;
            #1;
            hz = if_en && ex_en && ex_ld && !ex_we_ && ex_dst_addr != 0 && (ex_dst_addr == r1 || ex_dst_addr == r2);
            checks++;
            if (ld_hazard !== hz || gpr_rd_addr_0 !== r1 || gpr_rd_addr_1 !== r2) begin
                errors++; $display("FAIL rand_comb cycle %0d hz=%b addr=%0d,%0d want %b %0d,%0d",
                                   c, ld_hazard, gpr_rd_addr_0, gpr_rd_addr_1, hz, r1, r2);
            end
            if (flush || (!stall && hz)) begin
                e_en = 0; e_we = 1; e_ld = 0;
            end else if (!stall) begin
                e_en = if_en;
                e_we = !if_en || if_insn[6:0] == 7'b0100011 || if_insn[6:0] == 7'b1100011;
                e_ld = if_en && if_insn[6:0] == 7'b0000011;
                e_dst = if_insn[11:7]; e_insn = if_insn;
                e_rs1 = ref_operand(r1); e_rs2 = ref_operand(r2);
            end
            edge_sample();
            checks++;
            if (id_en !== e_en || id_we_ !== e_we || id_ld !== e_ld) begin
                errors++; $display("FAIL rand_ctrl cycle %0d en=%b we_=%b ld=%b want %b %b %b", c, id_en, id_we_, id_ld, e_en, e_we, e_ld);
            end
            if (e_en) begin
                checks++;
                if (id_insn !== e_insn || id_dst_addr !== e_dst || id_rs1_data !== e_rs1 || id_rs2_data !== e_rs2) begin
                    errors++; $display("FAIL rand_data cycle %0d insn=%h dst=%0d rs1=%h rs2=%h want %h %0d %h %h",
                                       c, id_insn, id_dst_addr, id_rs1_data, id_rs2_data, e_insn, e_dst, e_rs1, e_rs2);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_plain_read();
        test_forward_priority();
        test_x0();
        test_load_use();
        test_flush_stall();
        test_reset_mid_hazard();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_operand.md
ID_OPERAND -- requirements
Module: id_operand

Interface
REQ-001 SHALL have port clk  in  1  stage clock, all registers update on rising edge.
REQ-002 SHALL have port reset_  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port if_insn  in  32  instruction from fetch stage (RV32I encoding).
REQ-004 SHALL have port if_en  in  1  if_insn valid.
REQ-005 SHALL have port stall  in  1  hold all stage registers.
REQ-006 SHALL have port flush  in  1  squash instruction being captured.
REQ-007 SHALL have ports gpr_rd_addr_0, gpr_rd_addr_1  out  5  register-file read addresses.
REQ-008 SHALL have ports gpr_rd_data_0, gpr_rd_data_1  in  32  register-file read data, combinational from address.
REQ-009 SHALL have ports ex_en, ex_we_, ex_ld  in  1  EX valid, EX write enable (active-low), EX is load.
REQ-010 SHALL have ports ex_dst_addr  in  5, ex_fwd_data  in  32  EX destination and result.
REQ-011 SHALL have ports mem_en, mem_we_  in  1, mem_dst_addr  in  5, mem_fwd_data  in  32  MEM equivalents.
REQ-012 SHALL have ports id_en, id_we_, id_ld  out  1  registered valid, write enable (active-low), load flag.
REQ-013 SHALL have ports id_dst_addr  out  5, id_insn  out  32, id_rs1_data, id_rs2_data  out  32  registered stage outputs.
REQ-014 SHALL have port ld_hazard  out  1  combinational load-use stall request to fetch.

Function
REQ-015 SHALL drive gpr_rd_addr_0 = if_insn[19:15], gpr_rd_addr_1 = if_insn[24:20] combinationally.
REQ-016 SHALL select each operand by priority: address 0 -> 32'h0; EX match (ex_en & ~ex_we_ & ex_dst_addr==addr) -> ex_fwd_data; MEM match (same form) -> mem_fwd_data; else gpr_rd_data.
REQ-017 SHALL never forward from a destination address of 0.
REQ-018 SHALL assert ld_hazard when if_en & ex_en & ex_ld & ~ex_we_ & ex_dst_addr!=0 & ex_dst_addr matches rs1 or rs2 field.
REQ-019 SHALL decode id_dst_addr = if_insn[11:7]; id_we_ = 1 for opcodes 0100011 and 1100011, else 0; id_ld = 1 only for opcode 0000011.
REQ-020 SHALL apply per-edge priority: flush > stall > ld_hazard > normal.
REQ-021 flush: next id_en = 0, id_we_ = 1, id_ld = 0; data registers don't-care.
REQ-022 stall (no flush): all id_* registers hold current values.
REQ-023 ld_hazard (no flush/stall): capture bubble (id_en = 0, id_we_ = 1, id_ld = 0); fetch holds if_insn, so the instruction is re-captured next cycle with forwarded load data from MEM.
REQ-024 normal: id_en <= if_en; id_insn, id_dst_addr, id_rs1_data, id_rs2_data, id_we_, id_ld captured; when if_en = 0, id_we_ <= 1 and id_ld <= 0.
REQ-025 Latency: operand and decode from if_insn appear on id_* one rising edge later.
REQ-026 Simultaneous EX and MEM match on same address SHALL select EX.

Reset
REQ-027 On reset_ = 0, asynchronously: id_en = 0, id_we_ = 1, id_ld = 0, id_dst_addr = 0, id_insn = 32'h0, id_rs1_data = id_rs2_data = 32'h0.
REQ-028 Reset mid-stall or mid-hazard SHALL discard the held instruction; first edge after deassertion behaves as normal.
REQ-029 ld_hazard SHALL depend only on inputs, so it is valid during reset.

Verification
REQ-030 Reset: reset_=0 for 27 ns with if_en=1 -> all id_* at reset values; first edge after release captures if_insn.
REQ-031 Plain read: gpr x5=32'h1234, x6=32'h00FF, insn add x7,x5,x6 -> next edge id_rs1_data=32'h1234, id_rs2_data=32'h00FF, id_dst_addr=7, id_we_=0, id_en=1.
REQ-032 Forward priority: ex x5=32'hAAAA and mem x5=32'hBBBB both valid, gpr x5=32'h1234 -> id_rs1_data=32'hAAAA; drop ex -> 32'hBBBB.
REQ-033 x0: rs1=0 with ex_dst_addr=0, ex_fwd_data=32'hDEAD -> id_rs1_data=32'h0.
REQ-034 Load-use: ex lw x5 (ex_ld=1), if_insn uses x5 -> ld_hazard=1, next id_en=0; next cycle mem x5=32'h55 -> id_rs1_data=32'h55, id_en=1.
REQ-035 Flush+stall same cycle with id_en=1 -> next id_en=0; stall alone -> id_* unchanged over 3 cycles.
